// File: rtl/stdp_synapse.sv
`default_nettype none
// ============================================================================
// stdp_synapse
// One plastic synapse: pre/post eligibility traces, pair-based STDP weight
// update and a registered synaptic current. Depression is compiled in only
// when the macro STDP_LTD_EN is defined; otherwise learning is LTP-only.
// Rev 1.0
// ============================================================================
module stdp_synapse #(
  parameter logic [7:0] W_INIT      = 8'd64,
  parameter int         LEARN_SHIFT = 1,
  parameter logic [3:0] TRACE_MAX   = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_spike,
  input  logic       post_spike,
  input  logic       learn_en,
  output logic [7:0] current,
  output logic [7:0] weight,
  output logic [3:0] pre_trace,
  output logic [3:0] post_trace
);

  logic [7:0]        weight_q, weight_d;
  logic [7:0]        current_q, current_d;
  logic [3:0]        pre_trace_q, pre_trace_d;
  logic [3:0]        post_trace_q, post_trace_d;
  logic [3:0]        dp, dd;
  logic signed [9:0] w_sum;

  always_comb begin
    pre_trace_d  = pre_spike  ? TRACE_MAX :
                   ((pre_trace_q  != 4'd0) ? pre_trace_q  - 4'd1 : 4'd0);
    post_trace_d = post_spike ? TRACE_MAX :
                   ((post_trace_q != 4'd0) ? post_trace_q - 4'd1 : 4'd0);

    // Steps use the traces as registered before this edge, not the reloads.
    dp = (post_spike && learn_en) ? (pre_trace_q >> LEARN_SHIFT) : 4'd0;
`ifdef STDP_LTD_EN
    dd = (pre_spike && learn_en) ? (post_trace_q >> LEARN_SHIFT) : 4'd0;
`else
    dd = 4'd0;
`endif

    w_sum = $signed({2'b00, weight_q}) + $signed({6'd0, dp}) - $signed({6'd0, dd});
    if (w_sum < 10'sd0) begin
      weight_d = 8'd0;
    end else if (w_sum > 10'sd255) begin
      weight_d = 8'd255;
    end else begin
      weight_d = w_sum[7:0];
    end

    current_d = pre_spike ? weight_q : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_q     <= W_INIT;
      current_q    <= 8'd0;
      pre_trace_q  <= 4'd0;
      post_trace_q <= 4'd0;
    end else begin
      weight_q     <= weight_d;
      current_q    <= current_d;
      pre_trace_q  <= pre_trace_d;
      post_trace_q <= post_trace_d;
    end
  end

  assign weight     = weight_q;
  assign current    = current_q;
  assign pre_trace  = pre_trace_q;
  assign post_trace = post_trace_q;

endmodule
`default_nettype wire

// File: doc/stdp_synapse.md
STDP_SYNAPSE -- requirements
Module: stdp_synapse

Interface
REQ-001 The block SHALL have parameter W_INIT, default 64, the 8-bit weight value loaded on reset.
REQ-002 The block SHALL have parameter LEARN_SHIFT, default 1, the right-shift applied to a trace to form a weight step.
REQ-003 The block SHALL have parameter TRACE_MAX, default 15, the 4-bit value a trace is set to on a spike.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port pre_spike, input, 1 bit: presynaptic spike, one-cycle pulse.
REQ-007 The block SHALL have port post_spike, input, 1 bit: postsynaptic spike, taken from the downstream LIF neuron's spike output.
REQ-008 The block SHALL have port learn_en, input, 1 bit: when high, weight updates are enabled.
REQ-009 The block SHALL have port current, output, 8 bits: registered synaptic current that drives the LIF neuron's current input.
REQ-010 The block SHALL have port weight, output, 8 bits: the current synaptic weight register.
REQ-011 The block SHALL have port pre_trace, output, 4 bits: the presynaptic eligibility trace.
REQ-012 The block SHALL have port post_trace, output, 4 bits: the postsynaptic eligibility trace.

Function
REQ-013 On each edge, pre_trace SHALL load TRACE_MAX if pre_spike=1; otherwise it SHALL decrement by 1 and saturate at 0.
REQ-014 post_trace SHALL follow the same rule as REQ-013, driven by post_spike.
REQ-015 Every weight update SHALL use the trace values registered before the current edge, not the values being loaded on that edge.
REQ-016 LTP: on an edge with post_spike=1 and learn_en=1, the potentiation step SHALL be dp = pre_trace >> LEARN_SHIFT.
REQ-017 LTD: on an edge with pre_spike=1 and learn_en=1, the depression step SHALL be dd = post_trace >> LEARN_SHIFT.
REQ-018 The weight SHALL update to weight + dp - dd, computed in at least 10-bit signed arithmetic and clamped to the range 0..255.
REQ-019 When pre_spike and post_spike are both high on the same edge, dp and dd SHALL both be applied in that single cycle.
REQ-020 When learn_en=0, the weight SHALL hold; the traces and current SHALL continue to operate normally.
REQ-021 current SHALL take the pre-edge weight on an edge with pre_spike=1, and 0 otherwise, giving a latency of 1 cycle.
REQ-022 The block SHALL have no other state; no handshake applies, since spikes are level-sampled every cycle.

Reset
REQ-023 While rst=1, the block SHALL immediately set weight=W_INIT, pre_trace=0, post_trace=0 and current=0, regardless of clk.
REQ-024 Reset asserted mid-operation SHALL discard any pending update; the first edge after rst falls SHALL be processed normally.

Configuration
REQ-025 The block SHALL use the compile-time macro STDP_LTD_EN to select depression.
REQ-026 With STDP_LTD_EN defined, the block SHALL behave as REQ-017 to REQ-019.
REQ-027 With STDP_LTD_EN undefined, dd SHALL be 0 and post_trace SHALL still be generated and output, giving LTP-only learning.

Verification
REQ-028 The bench SHALL cover LTP: after reset, learn_en=1, pre_spike at edge E0, post_spike at E4 -> pre_trace=12 before E4, weight=70 after E4, post_trace=15.
REQ-029 The bench SHALL cover LTD with STDP_LTD_EN defined: post_spike at E0, pre_spike at E4 -> weight=58 after E4, current=64 after E4.
REQ-030 The bench SHALL cover saturation: W_INIT=250, pre_spike at E0, post_spike at E1 -> weight=255, not 257; with W_INIT=3, the mirrored LTD sequence -> weight=0.
REQ-031 The bench SHALL cover simultaneous spikes: pre_spike and post_spike together at E0 with both traces 0 -> weight unchanged at 64, both traces=15; a repeat at E1 -> dp=7, dd=7, weight stays 64.
REQ-032 The bench SHALL cover learning disabled: learn_en=0 with the REQ-028 sequence -> weight stays 64, traces match REQ-028.
REQ-033 The bench SHALL cover mid-operation reset: rst pulsed between E2 and E3 of the REQ-028 sequence -> immediately weight=64 and traces=0; post_spike at E4 -> weight stays 64.
